// File: rtl/ctrl_pkg.sv
// Shared definitions for the datapath controller: instruction fields,
// opcodes, ALU function selects, FSM states and decoded instruction classes.
package ctrl_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_ORR  = 6'h04;
  localparam logic [5:0] OP_EOR  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h06;
  localparam logic [5:0] OP_SUBI = 6'h07;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_ST   = 6'h09;
  localparam logic [5:0] OP_CBZ  = 6'h0A;
  localparam logic [5:0] OP_B    = 6'h0B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [4:0] FS_AND    = 5'h00;
  localparam logic [4:0] FS_ORR    = 5'h04;
  localparam logic [4:0] FS_ADD    = 5'h08;
  localparam logic [4:0] FS_SUB    = 5'h09;
  localparam logic [4:0] FS_EOR    = 5'h0C;
  localparam logic [4:0] FS_PASS_A = 5'h10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // ALU covers both register and immediate arithmetic/logic ops
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_CBZ,
    CLS_B,
    CLS_HALT,
    CLS_ILL
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static part of
// the datapath control word (ALU function, carry-in, constant mux, writeback).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  output iclass_t    cls,
  output logic [4:0] fs,
  output logic       c0,
  output logic       mux_sel,
  output logic       wb_sel,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_ILL;
    fs      = FS_ADD;
    c0      = 1'b0;
    mux_sel = 1'b0;
    wb_sel  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP:  cls = CLS_NOP;
      OP_ADD:  cls = CLS_ALU;
      OP_SUB:  begin cls = CLS_ALU; fs = FS_SUB; c0 = 1'b1; end
      OP_AND:  begin cls = CLS_ALU; fs = FS_AND; end
      OP_ORR:  begin cls = CLS_ALU; fs = FS_ORR; end
      OP_EOR:  begin cls = CLS_ALU; fs = FS_EOR; end
      OP_ADDI: begin cls = CLS_ALU; mux_sel = 1'b1; end
      OP_SUBI: begin cls = CLS_ALU; fs = FS_SUB; c0 = 1'b1; mux_sel = 1'b1; end
      // address = ra + constant for both memory ops
      OP_LD:   begin cls = CLS_LD; mux_sel = 1'b1; wb_sel = 1'b1; end
      OP_ST:   begin cls = CLS_ST; mux_sel = 1'b1; end
      OP_CBZ:  begin cls = CLS_CBZ; fs = FS_PASS_A; end
      OP_B:    begin cls = CLS_B; fs = FS_PASS_A; end
      OP_HALT: cls = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute sequencer driving the regfile/ALU/RAM datapath.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module datapath_controller
  import ctrl_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int K_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic [3:0]      status,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      sel_a,
  output logic [4:0]      sel_b,
  output logic [4:0]      sel_d,
  output logic            reg_wrt,
  output logic [4:0]      fs,
  output logic            c0,
  output logic            mux_sel,
  output logic [K_W-1:0]  k_out,
  output logic            ram_wrt,
  output logic            wb_sel,
  output logic            halted,
  output logic            illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  state_t          state_reg, state_next;
  logic [31:0]     ir_reg, ir_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pc_cur_reg, pc_cur_next;

  iclass_t    dec_cls;
  logic [4:0] dec_fs;
  logic       dec_c0, dec_mux_sel, dec_wb_sel, dec_illegal;

  logic [4:0]     rd_f, ra_f, rb_f;
  logic [K_W-1:0] k_ext;
  logic [PC_W-1:0] branch_target;
  logic           unused_flags;

  ctrl_decode u_decode (
    .op      (ir_reg[OP_MSB:OP_LSB]),
    .cls     (dec_cls),
    .fs      (dec_fs),
    .c0      (dec_c0),
    .mux_sel (dec_mux_sel),
    .wb_sel  (dec_wb_sel),
    .illegal (dec_illegal)
  );

  assign rd_f          = ir_reg[RD_MSB:RD_LSB];
  assign ra_f          = ir_reg[RA_MSB:RA_LSB];
  assign rb_f          = ir_reg[RB_MSB:RB_LSB];
  assign k_ext         = {{(K_W-16){ir_reg[IMM_MSB]}}, ir_reg[IMM_MSB:IMM_LSB]};
  assign branch_target = pc_cur_reg + k_ext[PC_W-1:0];
  assign pc            = pc_reg;
  assign unused_flags  = ^status[3:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_FETCH;
      ir_reg     <= '0;
      pc_reg     <= '0;
      pc_cur_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      pc_reg     <= pc_next;
      pc_cur_reg <= pc_cur_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    pc_next     = pc_reg;
    pc_cur_next = pc_cur_reg;
    fetch_req   = 1'b0;
    sel_a       = '0;
    sel_b       = '0;
    sel_d       = '0;
    reg_wrt     = 1'b0;
    fs          = '0;
    c0          = 1'b0;
    mux_sel     = 1'b0;
    k_out       = '0;
    ram_wrt     = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        // held low while reset is asserted so the request only appears after release
        fetch_req = reset;
        if (instr_valid) begin
          ir_next     = instr;
          pc_cur_next = pc_reg;
          state_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        pc_next = pc_reg + PC_W'(1);
        case (dec_cls)
          CLS_NOP:  state_next = ST_FETCH;
          CLS_ILL: begin
            illegal    = dec_illegal;
            state_next = ST_FETCH;
          end
          CLS_HALT: state_next = ST_HALT;
          default:  state_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_ALU:         state_next = ST_WB;
          CLS_LD, CLS_ST:  state_next = ST_MEM;
          CLS_CBZ: begin
            if (status[0]) pc_next = branch_target;
            state_next = ST_FETCH;
          end
          CLS_B: begin
            pc_next    = branch_target;
            state_next = ST_FETCH;
          end
          default:         state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dec_cls == CLS_ST) begin
          ram_wrt    = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        sel_d      = rd_f;
        reg_wrt    = 1'b1;
        wb_sel     = dec_wb_sel;
        state_next = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_FETCH;
    endcase

    // the control word set up in EXEC stays stable through MEM and WB
    if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
      sel_a   = ra_f;
      sel_b   = (dec_cls == CLS_ST) ? rd_f : rb_f;
      fs      = dec_fs;
      c0      = dec_c0;
      mux_sel = dec_mux_sel;
      k_out   = k_ext;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic        retire;
  logic [31:0] retired_reg;

  assign retire = (state_reg == ST_WB)
               || (state_reg == ST_MEM    && dec_cls == CLS_ST)
               || (state_reg == ST_EXEC   && (dec_cls == CLS_CBZ || dec_cls == CLS_B))
               || (state_reg == ST_DECODE && dec_cls == CLS_NOP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retired_reg <= '0;
    else if (retire) retired_reg <= retired_reg + 32'd1;
  end

  assign retired = retired_reg;
`endif

endmodule
